// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Request/response bundle for one master of dmem_arbiter.
//   Signals (master view):
//     req_valid  out  request present
//     req_ready  in   request accepted this cycle (combinational)
//     req_we     out  1 = write, 0 = read
//     req_addr   out  word address (ADDR_W)
//     req_wdata  out  write data (N)
//     req_lock   out  keep ownership after this request
//     resp_valid in   one-cycle pulse, the cycle after accept
//     resp_rdata in   read data (0 for writes), holds between responses
interface dmem_arbiter_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [N-1:0]      req_wdata;
    logic              req_lock;
    logic              resp_valid;
    logic [N-1:0]      resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_lock,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_lock,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single port of data_memory32 (combinational read, write on the
//   rising clock edge) between master 0 (core load/store) and master 1
//   (debug/DMA). Round-robin on conflict, optional per-master lock for atomic
//   sequences with forced release after LOCK_MAX consecutive locked grants.
//   Each accepted request gets a registered response one cycle later.
//   Ports:
//     clk              in   rising-edge clock
//     rst_n            in   asynchronous active-low reset
//     m0, m1           slave side of dmem_arbiter_if (request/response)
//     mem_write_enable out  to data_memory32.write_enable
//     mem_addr         out  to data_memory32.addr
//     mem_write_data   out  to data_memory32.write_data
//     mem_read_data    in   from data_memory32.read_data
module dmem_arbiter #(
    parameter int N        = 32,
    parameter int ADDR_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [N-1:0]      mem_write_data,
    input  logic [N-1:0]      mem_read_data
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0]  lock_cnt_inc;

    logic              grant0, grant1;
    logic              acc0, acc1, acc;
    logic              sel_we, sel_lock;

    logic              resp_valid0_q, resp_valid1_q;
    logic [N-1:0]      rdata0_q, rdata1_q;

    // Grant: an owner excludes the other master; otherwise a tie goes to the
    // master that did not win last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state_q)
            OWN0: grant0 = 1'b1;
            OWN1: grant1 = 1'b1;
            default: begin
                if (m0.req_valid && m1.req_valid) begin
                    grant0 = last_grant_q;
                    grant1 = !last_grant_q;
                end else begin
                    grant0 = m0.req_valid;
                    grant1 = m1.req_valid;
                end
            end
        endcase
    end

    // Gating with rst_n keeps any write off the memory while reset is held,
    // even though the grant logic itself is combinational.
    assign acc0 = grant0 && m0.req_valid && rst_n;
    assign acc1 = grant1 && m1.req_valid && rst_n;
    assign acc  = acc0 || acc1;

    assign m0.req_ready = acc0;
    assign m1.req_ready = acc1;

    // Only the accepted master's fields reach the memory; everything else is
    // forced to zero so undriven fields never leak onto the bus.
    always_comb begin
        sel_we         = 1'b0;
        sel_lock       = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (acc0) begin
            sel_we         = m0.req_we;
            sel_lock       = m0.req_lock;
            mem_addr       = m0.req_addr;
            mem_write_data = m0.req_wdata;
        end else if (acc1) begin
            sel_we         = m1.req_we;
            sel_lock       = m1.req_lock;
            mem_addr       = m1.req_addr;
            mem_write_data = m1.req_wdata;
        end
    end

    assign mem_write_enable = sel_we;

    assign lock_cnt_inc = lock_cnt_q + 1'b1;

    // Ownership only changes on an accept; idle cycles in OWNx leave the
    // count untouched.
    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        last_grant_d = last_grant_q;
        if (acc) begin
            last_grant_d = acc1;
            if (!sel_lock) begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end else if (state_q == IDLE) begin
                state_d    = acc1 ? OWN1 : OWN0;
                lock_cnt_d = CNT_W'(1);
            end else if (lock_cnt_inc == CNT_W'(LOCK_MAX)) begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end else begin
                lock_cnt_d = lock_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            lock_cnt_q    <= '0;
            resp_valid0_q <= 1'b0;
            resp_valid1_q <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            lock_cnt_q    <= lock_cnt_d;
            resp_valid0_q <= acc0;
            resp_valid1_q <= acc1;
            if (acc0) rdata0_q <= sel_we ? '0 : mem_read_data;
            if (acc1) rdata1_q <= sel_we ? '0 : mem_read_data;
        end
    end

    assign m0.resp_valid = resp_valid0_q;
    assign m0.resp_rdata = rdata0_q;
    assign m1.resp_valid = resp_valid1_q;
    assign m1.resp_rdata = rdata1_q;
endmodule
